rr_encoder_arbiter: RTL and testbench

- Round-robin arbiter that shares the lab's single encoder resource among N requesters.
- Selects one active request per transaction and drives a one-hot grant plus its binary-encoded index.
- Holds the grant until the owner releases it, then advances priority past that owner.
- Sits between the requesting blocks and the shared encoder datapath; the encoded index steers the encoder's input mux.

---
 rtl/rr_encoder_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_encoder_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter sharing one encoder among N requesters; optional watchdog via RR_ARB_WATCHDOG_EN.
// Latency: request to grant 1 cycle; grant held until Done or owner withdraws, then 1 dead cycle.
// Backpressure: holders keep Req high; other requesters wait, priority advances past the last owner.
module rr_encoder_arbiter #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [N-1:0]   Req,
  input  logic           Done,
  output logic [N-1:0]   Grant,
  output logic [IDW-1:0] GrantIdx,
  output logic           GrantValid,
  output logic           Timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last, last_nxt;
  logic [N-1:0]   grant_nxt;
  logic [IDW-1:0] idx_nxt;
  logic           valid_nxt;
  logic           timeout_nxt;

  logic           found;
  logic [IDW-1:0] winner;
  logic           owner_release;
  logic           wd_fire;

  // Search Req from the slot after the last owner, wrapping, first set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int off = 1; off <= N; off++) begin
      int cand;
      cand = (int'(last) + off) % N;
      if (!found && Req[cand]) begin
        found  = 1'b1;
        winner = IDW'(cand);
      end
    end
  end

  // Normal release: owner signals Done or drops its own request.
  assign owner_release = Done || !Req[GrantIdx];

`ifdef RR_ARB_WATCHDOG_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;

  // Hold counter: zero outside BUSY, so it starts at zero on every BUSY entry.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_cnt <= '0;
    end else if (state != BUSY) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // Fires in the MAX_HOLD-th BUSY cycle so the grant drops after exactly MAX_HOLD cycles.
  assign wd_fire = (state == BUSY) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign wd_fire = 1'b0;
`endif

  // Next-state and next-output logic; everything defaults to holding or clearing.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    grant_nxt   = Grant;
    idx_nxt     = GrantIdx;
    valid_nxt   = GrantValid;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        if (found) begin
          grant_nxt = {{(N-1){1'b0}}, 1'b1} << winner;
          idx_nxt   = winner;
          valid_nxt = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (owner_release || wd_fire) begin
          last_nxt    = GrantIdx;
          grant_nxt   = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          timeout_nxt = wd_fire && !owner_release;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        grant_nxt = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, priority pointer and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      last       <= IDW'(N - 1);
      Grant      <= '0;
      GrantIdx   <= '0;
      GrantValid <= 1'b0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      Grant      <= grant_nxt;
      GrantIdx   <= idx_nxt;
      GrantValid <= valid_nxt;
    end
  end

`ifdef RR_ARB_WATCHDOG_EN
  // Timeout is high for the cycle in which a forced release clears the grant.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Timeout <= 1'b0;
    end else begin
      Timeout <= timeout_nxt;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = timeout_nxt;
  assign Timeout        = (MAX_HOLD < 0);
`endif

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter with N=8: reset, grant, rotation, wrap, withdrawal.
// Inputs change 1ns after the rising edge; outputs are checked there as well.
// Expected values are hand-computed constants in each step.
module tb_rr_encoder_arbiter;

  logic       Clk;
  logic       Reset;
  logic [7:0] Req;
  logic       Done;
  logic [7:0] Grant;
  logic [2:0] GrantIdx;
  logic       GrantValid;
  logic       Timeout;

  int checks = 0;
  int errors = 0;

  rr_encoder_arbiter #(.N(8), .IDW(3), .MAX_HOLD(15)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .Done       (Done),
    .Grant      (Grant),
    .GrantIdx   (GrantIdx),
    .GrantValid (GrantValid),
    .Timeout    (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] idx, input logic v);
    check({tag, "_grant"}, 32'(Grant), 32'(g));
    check({tag, "_idx"}, 32'(GrantIdx), 32'(idx));
    check({tag, "_valid"}, 32'(GrantValid), 32'(v));
    check({tag, "_timeout"}, 32'(Timeout), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Req   = 8'h00;
    Done  = 1'b0;
    #1;
    expect_out("reset", 8'h00, 3'd0, 1'b0);
    step();
    step();
    Reset = 1'b0;

    // Basic grant from reset priority, then Done release and dead cycle.
    Req = 8'h10;
    step();
    expect_out("basic_grant", 8'h10, 3'd4, 1'b1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    Req  = 8'h00;
    expect_out("basic_release", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("basic_idle", 8'h00, 3'd0, 1'b0);

    // Move pointer to 6, then Req=05 wraps to 0, then advances to 2.
    Req = 8'h40;
    step();
    expect_out("wrap_own6", 8'h40, 3'd6, 1'b1);
    Req = 8'h05;
    step();
    expect_out("wrap_rel6", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("wrap_idle", 8'h00, 3'd0, 1'b0);
    step();
    expect_out("wrap_grant0", 8'h01, 3'd0, 1'b1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    step();
    step();
    expect_out("wrap_grant2", 8'h04, 3'd2, 1'b1);
    Req = 8'h00;
    step();
    step();

    // Last=2: Req=04 searches 3..7,0,1,2 and grants 2 again; reset mid-BUSY clears asynchronously.
    Req = 8'h04;
    step();
    expect_out("rst_pre", 8'h04, 3'd2, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    expect_out("rst_async", 8'h00, 3'd0, 1'b0);
    #2;
    Reset = 1'b0;
    Req   = 8'h81;
    step();
    expect_out("rst_prio0", 8'h01, 3'd0, 1'b1);
    Req = 8'h00;
    step();
    step();

    // Fresh reset, then full rotation with one-cycle holds: 0..7,0 every 3 cycles.
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    Req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [2:0] ei;
      ei = 3'(k % 8);
      step();
      expect_out($sformatf("rot%0d", k), 8'h01 << ei, ei, 1'b1);
      Done = 1'b1;
      step();
      Done = 1'b0;
      check($sformatf("rot%0d_rel", k), 32'(GrantValid), 32'd0);
      step();
      check($sformatf("rot%0d_idle", k), 32'(GrantValid), 32'd0);
    end
    Req = 8'h00;
    step();
    step();

    // Last=0: grant 3, Req[5] rises (ignored), drop Req[3] (release), Done in IDLE ignored.
    Req = 8'h08;
    step();
    expect_out("wd_grant3", 8'h08, 3'd3, 1'b1);
    Req = 8'h28;
    step();
    expect_out("ign_hold3", 8'h08, 3'd3, 1'b1);
    step();
    expect_out("ign_hold3b", 8'h08, 3'd3, 1'b1);
    Req = 8'h20;
    step();
    expect_out("withdraw_rel", 8'h00, 3'd0, 1'b0);
    Req = 8'h00;
    step();
    Done = 1'b1;
    step();
    Done = 1'b0;
    expect_out("done_in_idle", 8'h00, 3'd0, 1'b0);
    Req = 8'h20;
    step();
    expect_out("after_idle_grant5", 8'h20, 3'd5, 1'b1);
    Req = 8'h00;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
